mnk_game: RTL

MNK_GAME -- requirements
Module: mnk_game

---
 rtl/mnk_game_pkg.sv | 21 ++
 rtl/mnk_game_if.sv | 43 ++++
 rtl/mnk_win_checker.sv | 106 ++++++++++
 rtl/mnk_game.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mnk_game_pkg.sv
// Shared encodings for the m,n,k game: one-hot controller states and board cell codes.
package mnk_game_pkg;

  typedef enum logic [5:0] {
    ST_INI  = 6'b000001,
    ST_STA  = 6'b000010,
    ST_XTU  = 6'b000100,
    ST_OTU  = 6'b001000,
    ST_CHK  = 6'b010000,
    ST_DONE = 6'b100000
  } state_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  function automatic logic [1:0] mark_of(input logic o_turn);
    return o_turn ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/mnk_game_if.sv
// Player/display bundle of the game: buttons and read port in, status and scores out.
interface mnk_game_if #(
  parameter int BOARD_N = 3,
  parameter int SCORE_W = 12
);
  localparam int AW = $clog2(BOARD_N * BOARD_N);

  logic               start;
  logic               ack;
  logic               btn_l;
  logic               btn_r;
  logic               btn_u;
  logic               btn_d;
  logic               btn_c;
  logic [AW-1:0]      rd_addr;
  logic [1:0]         rd_cell;
  logic [AW-1:0]      cursor;
  logic               q_i;
  logic               q_s;
  logic               q_x;
  logic               q_o;
  logic               q_c;
  logic               q_d;
  logic               x_wins;
  logic               o_wins;
  logic               draw;
  logic               illegal;
  logic [SCORE_W-1:0] p1s;
  logic [SCORE_W-1:0] p2s;

  modport master (
    output start, ack, btn_l, btn_r, btn_u, btn_d, btn_c, rd_addr,
    input  rd_cell, cursor, q_i, q_s, q_x, q_o, q_c, q_d,
    input  x_wins, o_wins, draw, illegal, p1s, p2s
  );

  modport slave (
    input  start, ack, btn_l, btn_r, btn_u, btn_d, btn_c, rd_addr,
    output rd_cell, cursor, q_i, q_s, q_x, q_o, q_c, q_d,
    output x_wins, o_wins, draw, illegal, p1s, p2s
  );

endinterface

// File: rtl/mnk_win_checker.sv
// Walks the four lines through the last placed cell, one neighbour per cycle, both ways.
module mnk_win_checker
  import mnk_game_pkg::*;
#(
  parameter  int BOARD_N = 3,
  parameter  int WIN_K   = 3,
  localparam int CELLS   = BOARD_N * BOARD_N,
  localparam int AW      = $clog2(CELLS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*CELLS-1:0] board,
  input  logic [AW-1:0]      placed,
  output logic               done,
  output logic               win
);
  localparam int RW = $clog2(BOARD_N);

  logic          busy;
  logic          side;
  logic          fresh;
  logic [1:0]    dir;
  logic [3:0]    run;
  logic [RW-1:0] pos_row;
  logic [RW-1:0] pos_col;
  logic [1:0]    mark_s;
  logic [AW-1:0] nidx_s;
  logic          in_s;
  logic          hit_s;
  int            org_row_s;
  int            org_col_s;
  int            dr_s;
  int            dc_s;
  int            nr_s;
  int            nc_s;

  // Next neighbour along the current direction and side; "fresh" means restart at the placed cell.
  always_comb begin
    org_row_s = int'(placed) / BOARD_N;
    org_col_s = int'(placed) % BOARD_N;
    mark_s    = board[{placed, 1'b0} +: 2];
    case (dir)
      2'd0:    begin dr_s = 0; dc_s = 1;  end
      2'd1:    begin dr_s = 1; dc_s = 0;  end
      2'd2:    begin dr_s = 1; dc_s = 1;  end
      2'd3:    begin dr_s = 1; dc_s = -1; end
      default: begin dr_s = 0; dc_s = 0;  end
    endcase
    nr_s   = (fresh ? org_row_s : int'(pos_row)) + (side ? -dr_s : dr_s);
    nc_s   = (fresh ? org_col_s : int'(pos_col)) + (side ? -dc_s : dc_s);
    in_s   = (nr_s >= 0) && (nr_s < BOARD_N) && (nc_s >= 0) && (nc_s < BOARD_N);
    nidx_s = in_s ? AW'(nr_s * BOARD_N + nc_s) : '0;
    hit_s  = in_s && (board[{nidx_s, 1'b0} +: 2] == mark_s);
  end

  // Run counting needs no step limit: reaching K-1 steps on one side already yields a win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      side    <= 1'b0;
      fresh   <= 1'b0;
      dir     <= 2'd0;
      run     <= 4'd0;
      pos_row <= '0;
      pos_col <= '0;
      done    <= 1'b0;
      win     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        dir   <= 2'd0;
        side  <= 1'b0;
        fresh <= 1'b1;
        run   <= 4'd1;
        win   <= 1'b0;
      end else if (busy) begin
        if (hit_s && (run + 4'd1 >= 4'(WIN_K))) begin
          busy <= 1'b0;
          done <= 1'b1;
          win  <= 1'b1;
        end else if (hit_s) begin
          run     <= run + 4'd1;
          pos_row <= RW'(nr_s);
          pos_col <= RW'(nc_s);
          fresh   <= 1'b0;
        end else if (!side) begin
          side  <= 1'b1;
          fresh <= 1'b1;
        end else if (dir == 2'd3) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          dir   <= dir + 2'd1;
          side  <= 1'b0;
          fresh <= 1'b1;
          run   <= 4'd1;
        end
      end else begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mnk_game.sv
// Two-player m,n,k game controller: cursor, placement, round results and saturating scores.
module mnk_game
  import mnk_game_pkg::*;
#(
  parameter int BOARD_N = 3,
  parameter int WIN_K   = 3,
  parameter int SCORE_W = 12
) (
  input logic       clk,
  input logic       rst,
  mnk_game_if.slave bus
);
  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int AW    = $clog2(CELLS);

  state_t             state;
  logic [2*CELLS-1:0] board;
  logic [AW-1:0]      cursor;
  logic [AW-1:0]      placed;
  logic [AW:0]        moves;
  logic               start_o;
  logic               x_wins;
  logic               o_wins;
  logic               draw;
  logic               illegal;
  logic [SCORE_W-1:0] p1s;
  logic [SCORE_W-1:0] p2s;

  logic [1:0]    cur_cell_s;
  logic [1:0]    placed_mark_s;
  logic [AW-1:0] mv_left_s;
  logic [AW-1:0] mv_right_s;
  logic [AW-1:0] mv_up_s;
  logic [AW-1:0] mv_down_s;
  logic          turn_s;
  logic          place_ok_s;
  logic          chk_done_s;
  logic          chk_win_s;
  int            row_s;
  int            col_s;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
  endfunction

  assign cur_cell_s    = board[{cursor, 1'b0} +: 2];
  assign placed_mark_s = board[{placed, 1'b0} +: 2];
  assign turn_s        = (state == ST_XTU) || (state == ST_OTU);
  assign place_ok_s    = turn_s && bus.btn_c && (cur_cell_s == CELL_EMPTY);

  // Wrapped cursor targets; moves stay inside the current row or column.
  always_comb begin
    row_s      = int'(cursor) / BOARD_N;
    col_s      = int'(cursor) % BOARD_N;
    mv_left_s  = (col_s == 0)           ? cursor + AW'(BOARD_N - 1)     : cursor - AW'(1);
    mv_right_s = (col_s == BOARD_N - 1) ? cursor - AW'(BOARD_N - 1)     : cursor + AW'(1);
    mv_up_s    = (row_s == 0)           ? cursor + AW'(CELLS - BOARD_N) : cursor - AW'(BOARD_N);
    mv_down_s  = (row_s == BOARD_N - 1) ? cursor - AW'(CELLS - BOARD_N) : cursor + AW'(BOARD_N);
  end

  mnk_win_checker #(
    .BOARD_N (BOARD_N),
    .WIN_K   (WIN_K)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .start  (place_ok_s),
    .board  (board),
    .placed (placed),
    .done   (chk_done_s),
    .win    (chk_win_s)
  );

  // Round controller; leaving DONE through Ack clears the scores on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_INI;
      board   <= '0;
      cursor  <= '0;
      placed  <= '0;
      moves   <= '0;
      start_o <= 1'b0;
      x_wins  <= 1'b0;
      o_wins  <= 1'b0;
      draw    <= 1'b0;
      illegal <= 1'b0;
      p1s     <= '0;
      p2s     <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        ST_INI: begin
          p1s     <= '0;
          p2s     <= '0;
          start_o <= 1'b0;
          state   <= bus.start ? ST_STA : ST_INI;
        end
        ST_STA: begin
          board   <= '0;
          moves   <= '0;
          cursor  <= '0;
          x_wins  <= 1'b0;
          o_wins  <= 1'b0;
          draw    <= 1'b0;
          start_o <= ~start_o;
          state   <= start_o ? ST_OTU : ST_XTU;
        end
        ST_XTU, ST_OTU: begin
          if (place_ok_s) begin
            board[{cursor, 1'b0} +: 2] <= mark_of(state == ST_OTU);
            moves  <= moves + (AW + 1)'(1);
            placed <= cursor;
            state  <= ST_CHK;
          end else if (bus.btn_c) begin
            illegal <= 1'b1;
          end else if (bus.btn_u) begin
            cursor <= mv_up_s;
          end else if (bus.btn_d) begin
            cursor <= mv_down_s;
          end else if (bus.btn_l) begin
            cursor <= mv_left_s;
          end else if (bus.btn_r) begin
            cursor <= mv_right_s;
          end else begin
            cursor <= cursor;
          end
        end
        ST_CHK: begin
          if (chk_done_s && chk_win_s) begin
            state <= ST_DONE;
            if (placed_mark_s == CELL_X) begin
              x_wins <= 1'b1;
              p1s    <= sat_inc(p1s);
            end else begin
              o_wins <= 1'b1;
              p2s    <= sat_inc(p2s);
            end
          end else if (chk_done_s && (moves == (AW + 1)'(CELLS))) begin
            draw  <= 1'b1;
            state <= ST_DONE;
          end else if (chk_done_s) begin
            state <= (placed_mark_s == CELL_X) ? ST_OTU : ST_XTU;
          end else begin
            state <= ST_CHK;
          end
        end
        ST_DONE: begin
          if (bus.ack) begin
            p1s     <= '0;
            p2s     <= '0;
            start_o <= 1'b0;
            state   <= ST_INI;
          end else if (bus.btn_c) begin
            state <= ST_STA;
          end else begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_INI;
      endcase
    end
  end

  assign bus.rd_cell = (int'(bus.rd_addr) < CELLS) ? board[{bus.rd_addr, 1'b0} +: 2] : CELL_EMPTY;
  assign bus.cursor  = cursor;
  assign bus.q_i     = (state == ST_INI);
  assign bus.q_s     = (state == ST_STA);
  assign bus.q_x     = (state == ST_XTU);
  assign bus.q_o     = (state == ST_OTU);
  assign bus.q_c     = (state == ST_CHK);
  assign bus.q_d     = (state == ST_DONE);
  assign bus.x_wins  = x_wins;
  assign bus.o_wins  = o_wins;
  assign bus.draw    = draw;
  assign bus.illegal = illegal;
  assign bus.p1s     = p1s;
  assign bus.p2s     = p2s;

endmodule
